// File: rtl/alu_writeback_seq.sv
// alu_writeback_seq: writeback sequencer between the ALU and the single-write-port
// register file. Narrow results take one write cycle; wide results (MULT/DIV)
// write the low half to in_dest, then the high half to HI_REG.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready result handshake (in_ready depends on state and rst only)
//   in_result         2*DATA_W result {high, low}
//   in_wide           result needs a second (high-half) write
//   in_dest           destination register for the low half
//   in_stat, clr_ovf  ALU flags {sign, overflow, zero} and sticky-overflow clear
//   rf_we/rf_waddr/rf_wdata  register-file write port (addr/data are 0 when idle)
//   stat_q, ovf_sticky       latched flags and sticky overflow
//
// Optional feature macro: ALU_WB_STATUS_REG_EN enables the status flag register;
// without it stat_q/ovf_sticky are tied to 0.
module alu_writeback_seq #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RADDR_W = 4,
    parameter int unsigned HI_REG  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DATA_W-1:0]   in_result,
    input  logic                  in_wide,
    input  logic [RADDR_W-1:0]    in_dest,
    input  logic [2:0]            in_stat,
    input  logic                  clr_ovf,
    output logic                  rf_we,
    output logic [RADDR_W-1:0]    rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [2:0]            stat_q,
    output logic                  ovf_sticky
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  ready_c;
    logic                  accept;
    logic [2*DATA_W-1:0]   result_q;
    logic                  wide_q;
    logic [RADDR_W-1:0]    dest_q;

    // in_ready is forced low while rst is asserted
    assign in_ready = ready_c && !rst;
    assign accept   = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and write-port drive; outputs come straight from flops via a mux
    always_comb begin
        state_d  = state_q;
        ready_c  = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (in_valid) state_d = WR_LO;
            end
            WR_LO: begin
                rf_we    = 1'b1;
                rf_waddr = dest_q;
                rf_wdata = result_q[DATA_W-1:0];
                ready_c  = !wide_q;
                if (wide_q)        state_d = WR_HI;
                else if (in_valid) state_d = WR_LO;
                else               state_d = IDLE;
            end
            WR_HI: begin
                rf_we    = 1'b1;
                rf_waddr = RADDR_W'(HI_REG);
                rf_wdata = result_q[2*DATA_W-1:DATA_W];
                ready_c  = 1'b1;
                if (in_valid) state_d = WR_LO;
                else          state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register, loaded on every accepted transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            wide_q   <= 1'b0;
            dest_q   <= '0;
        end else if (accept) begin
            result_q <= in_result;
            wide_q   <= in_wide;
            dest_q   <= in_dest;
        end
    end

`ifdef ALU_WB_STATUS_REG_EN
    // Status flags; a new overflow on accept takes priority over clr_ovf
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q     <= 3'b000;
            ovf_sticky <= 1'b0;
        end else begin
            if (accept) stat_q <= in_stat;
            if (accept && in_stat[1]) ovf_sticky <= 1'b1;
            else if (clr_ovf)         ovf_sticky <= 1'b0;
        end
    end
`else
    logic unused_flags;
    assign unused_flags = ^{in_stat, clr_ovf};
    assign stat_q       = 3'b000;
    assign ovf_sticky   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_writeback_seq.sv
// Testbench for alu_writeback_seq: directed cases plus random traffic checked
// against a write-queue reference model of the writeback stream.
module tb_alu_writeback_seq;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned RADDR_W = 4;
    localparam int unsigned HI_REG  = 0;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [2*DATA_W-1:0]  in_result = '0;
    logic                 in_wide = 1'b0;
    logic [RADDR_W-1:0]   in_dest = '0;
    logic [2:0]           in_stat = '0;
    logic                 clr_ovf = 1'b0;
    logic                 rf_we;
    logic [RADDR_W-1:0]   rf_waddr;
    logic [DATA_W-1:0]    rf_wdata;
    logic [2:0]           stat_q;
    logic                 ovf_sticky;

    alu_writeback_seq #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .HI_REG(HI_REG)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_wide(in_wide), .in_dest(in_dest),
        .in_stat(in_stat), .clr_ovf(clr_ovf), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .stat_q(stat_q),
        .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RADDR_W-1:0] a;
        logic [DATA_W-1:0]  d;
    } wr_t;

    // Model: queue of writes still owed to the register file; head is the one on the port
    wr_t               wq[$];
    logic [DATA_W-1:0] rf_m   [16] = '{default: '0};
    logic [DATA_W-1:0] rf_dut [16] = '{default: '0};
    logic [2:0]        stat_m = 3'b000;
    logic              ovf_m  = 1'b0;

    int errors = 0;
    int checks = 0;

    // Register file as seen by the DUT's write port
    always @(posedge clk) begin
        if (rf_we) rf_dut[rf_waddr] <= rf_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_port();
        logic busy;
        busy = (wq.size() > 0);
        chk("rf_we", 32'(rf_we), 32'(busy));
        chk("rf_waddr", 32'(rf_waddr), busy ? 32'(wq[0].a) : 32'd0);
        chk("rf_wdata", 32'(rf_wdata), busy ? 32'(wq[0].d) : 32'd0);
        chk("in_ready", 32'(in_ready), 32'(wq.size() <= 1));
        chk("stat_q", 32'(stat_q), 32'(stat_m));
        chk("ovf_sticky", 32'(ovf_sticky), 32'(ovf_m));
    endtask

    // One clock: check outputs, drive inputs, then advance the model at the edge
    task automatic step(input logic v, input logic [31:0] r, input logic w,
                        input logic [3:0] d, input logic [2:0] s, input logic c,
                        output logic acc);
        wr_t e;
        @(negedge clk);
        check_port();
        in_valid  = v;
        in_result = r;
        in_wide   = w;
        in_dest   = d;
        in_stat   = s;
        clr_ovf   = c;
        acc = v && (wq.size() <= 1);
        @(posedge clk);
        if (wq.size() > 0) begin
            rf_m[wq[0].a] = wq[0].d;
            void'(wq.pop_front());
        end
        if (acc) begin
            e.a = d; e.d = r[15:0];
            wq.push_back(e);
            if (w) begin
                e.a = 4'(HI_REG); e.d = r[31:16];
                wq.push_back(e);
            end
        end
`ifdef ALU_WB_STATUS_REG_EN
        if (acc) stat_m = s;
        if (acc && s[1]) ovf_m = 1'b1;
        else if (c)      ovf_m = 1'b0;
`endif
    endtask

    logic        acc;
    logic        cv, cw, cc;
    logic [31:0] cr;
    logic [3:0]  cd;
    logic [2:0]  cs;

    initial begin
        // Reset state
        #3;
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", 32'(rf_wdata), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_stat", 32'(stat_q), 32'd0);
        chk("rst_ovf", 32'(ovf_sticky), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // Narrow
        step(1, 32'h0000_1234, 0, 4'd3, 3'b010, 0, acc);
        step(0, 32'h0, 0, 4'd0, 3'b000, 0, acc);
        step(0, 32'h0, 0, 4'd0, 3'b000, 0, acc);
        // Wide
        step(1, 32'hABCD_5678, 1, 4'd5, 3'b001, 0, acc);
        step(0, 32'h0, 0, 4'd0, 3'b000, 0, acc);
        step(0, 32'h0, 0, 4'd0, 3'b000, 1, acc);
        step(0, 32'h0, 0, 4'd0, 3'b000, 0, acc);
        chk("wide_lo_rf5", 32'(rf_dut[5]), 32'h5678);
        // Back-to-back narrow
        step(1, 32'h0000_0001, 0, 4'd1, 3'b000, 0, acc);
        step(1, 32'h0000_0002, 0, 4'd2, 3'b000, 0, acc);
        step(1, 32'h0000_0003, 0, 4'd3, 3'b000, 0, acc);
        step(0, 32'h0, 0, 4'd0, 3'b000, 0, acc);
        step(0, 32'h0, 0, 4'd0, 3'b000, 0, acc);
        chk("b2b_rf3", 32'(rf_dut[3]), 32'h0003);
        // Wide to HI_REG: low then high land in the same register
        step(1, 32'h0001_0002, 1, 4'd0, 3'b000, 0, acc);
        step(0, 32'h0, 0, 4'd0, 3'b000, 0, acc);
        step(0, 32'h0, 0, 4'd0, 3'b000, 0, acc);
        step(0, 32'h0, 0, 4'd0, 3'b000, 0, acc);
        chk("conflict_rf0", 32'(rf_dut[0]), 32'h0001);

        // Reset while the high half is on the port
        step(1, 32'h1357_2468, 1, 4'd7, 3'b010, 0, acc);
        step(0, 32'h0, 0, 4'd0, 3'b000, 0, acc);
        #2;
        chk("pre_rst_we", 32'(rf_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(rf_we), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_ovf", 32'(ovf_sticky), 32'd0);
        wq.delete();
        stat_m = 3'b000;
        ovf_m  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(0, 32'h0, 0, 4'd0, 3'b000, 0, acc);
        step(0, 32'h0, 0, 4'd0, 3'b000, 0, acc);
        chk("rst_lo_kept", 32'(rf_dut[7]), 32'h2468);
        chk("rst_hi_dropped", 32'(rf_dut[HI_REG]), 32'(rf_m[HI_REG]));

        // Random traffic; an unaccepted request is held stable
        cv = 0; cr = '0; cw = 0; cd = '0; cs = '0; acc = 1;
        for (int i = 0; i < 400; i++) begin
            if (!cv || acc) begin
                cv = ($urandom_range(0, 3) != 0);
                cr = $urandom;
                cw = $urandom_range(0, 1) == 1;
                cd = 4'($urandom_range(0, 15));
                cs = 3'($urandom_range(0, 7));
            end
            cc = ($urandom_range(0, 7) == 0);
            step(cv, cr, cw, cd, cs, cc, acc);
        end
        for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 4'd0, 3'b000, 0, acc);
        for (int i = 0; i < 16; i++) chk($sformatf("rf_final_%0d", i), 32'(rf_dut[i]), 32'(rf_m[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_writeback_seq.md
# alu_writeback_seq

Writeback sequencer directly downstream of the ALU. Accepts one 32-bit ALU result per transaction through a valid/ready handshake and drives the single-write-port register file. Narrow results take one write cycle. Wide results (MULT product, DIV remainder:quotient) take two write cycles: the low half goes to the destination register, then the high half goes to the fixed high-result register. Optionally latches the ALU status flags into an architectural status register.

## Interface
Parameters:
- DATA_W, 16, register-file word width; the ALU result is 2*DATA_W.
- RADDR_W, 4, register address width.
- HI_REG, 0, register address that receives the upper half of wide results.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  sequencer can accept at this edge.
- in_result  in  2*DATA_W  ALU result; [DATA_W-1:0] low, [2*DATA_W-1:DATA_W] high.
- in_wide  in  1  result is wide (MULT/DIV); high half must be written.
- in_dest  in  RADDR_W  destination register for the low half.
- in_stat  in  3  ALU flags {sign, overflow, zero}.
- clr_ovf  in  1  clears the sticky overflow (STATUS_REG_EN only).
- rf_we  out  1  register-file write enable.
- rf_waddr  out  RADDR_W  write address.
- rf_wdata  out  DATA_W  write data.
- stat_q  out  3  latched {sign, overflow, zero}.
- ovf_sticky  out  1  sticky overflow.

## Operation
- Holding register: result_q, wide_q, dest_q. Loaded on accept, i.e. when in_valid && in_ready at a clk edge.
- FSM states: IDLE, WR_LO, WR_HI.
  - IDLE: rf_we=0. On accept → WR_LO; otherwise stay.
  - WR_LO: rf_we=1, rf_waddr=dest_q, rf_wdata=result_q[DATA_W-1:0]. If wide_q → WR_HI. Else on accept → WR_LO, back-to-back. Else → IDLE.
  - WR_HI: rf_we=1, rf_waddr=HI_REG, rf_wdata=result_q[2*DATA_W-1:DATA_W]. On accept → WR_LO. Else → IDLE.
- in_ready = !rst && (state==IDLE || (state==WR_LO && !wide_q) || state==WR_HI). It is combinational from state only and never depends on in_valid.
- When in_ready=0, in_result, in_wide and in_dest are ignored. The producer must hold them stable until accepted.
- When rf_we=0, rf_waddr and rf_wdata are don't-care but must not be X after reset. They drive 0.
- Wide result with dest==HI_REG: both writes still occur, low first then high. The register ends holding the high half.
- Narrow results never touch HI_REG unless dest==HI_REG.

## Timing
- Reset (async, immediate): state=IDLE, holding register=0. Outputs: rf_we=0, rf_waddr=0, rf_wdata=0, in_ready=0 while rst is high and 1 after release. stat_q=0, ovf_sticky=0.
- Latency: accept at edge N → low write visible in cycle N..N+1 and committed by the register file at edge N+1. For wide results the high write is committed at edge N+2.
- Throughput: one narrow result per cycle, or one wide result per two cycles.
- Reset mid-transaction: the pending write is dropped immediately and rf_we falls without waiting for clk. A wide transaction interrupted in WR_HI leaves the low half written and the high half unwritten.

## Configuration
- Macro ALU_WB_STATUS_REG_EN.
- Defined:
  - stat_q loads in_stat on every accept.
  - ovf_sticky sets on accept when in_stat[1]=1, and clears when clr_ovf=1.
  - Simultaneous set and clear: set wins.
- Undefined: stat_q and ovf_sticky are constant 0, clr_ovf is ignored, and no flag flops are inferred.

## Test plan
- Narrow: accept result 32'h0000_1234, dest=3, wide=0 → next cycle rf_we=1, waddr=3, wdata=16'h1234. The following cycle rf_we=0 and in_ready stays 1 throughout.
- Wide: accept 32'hABCD_5678, dest=5, wide=1 → cycle+1 writes 5←16'h5678 with in_ready=0. Cycle+2 writes 0←16'hABCD with in_ready=1. Then idle.
- Back-to-back: valid held for three narrow results (dest 1,2,3; data 1,2,3) → three consecutive rf_we cycles with no bubble.
- Conflict: wide 32'h0001_0002, dest=HI_REG=0 → writes 0←2 then 0←1; register 0 final value is 1.
- Reset in WR_HI: assert rst asynchronously mid-cycle → rf_we drops the same cycle and in_ready=0. After release, in_ready=1 and no stale write occurs.
- With ALU_WB_STATUS_REG_EN: accept with in_stat=3'b010 → stat_q=3'b010 and ovf_sticky=1. Accept in_stat=3'b001 → ovf_sticky stays 1. Pulse clr_ovf → 0. Without the macro, stat_q and ovf_sticky stay 0.
